// File: rtl/imem_boot_controller.sv
// Boot sequencer: holds the core in reset while a host loads imem, then releases it and pulses run.
// Latency: every command takes effect on the registered outputs one cycle after acceptance; cmd_ready_o is low only in RELEASE.
module imem_boot_controller #(
    parameter logic [31:0] START_ADDR     = 32'h8000_0000,
    parameter int unsigned DEPTH          = 12,
    parameter int unsigned RELEASE_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [31:0]      cmd_data_i,
    output logic             core_reset_o,
    output logic             run_o,
    output logic [31:0]      insn_addr_o,
    output logic [31:0]      insn_din_o,
    output logic             insn_we_o,
    output logic [DEPTH:0]   word_count_o,
    output logic             err_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    localparam logic [1:0] OP_SET_ADDR = 2'd0;
    localparam logic [1:0] OP_WRITE    = 2'd1;
    localparam logic [1:0] OP_START    = 2'd2;
    localparam logic [1:0] OP_HALT     = 2'd3;

    // End bound is computed one bit wider so a window touching 2^32 cannot overflow.
    localparam logic [32:0]    END_ADDR = {1'b0, START_ADDR} + (33'd4 << DEPTH);
    localparam logic [DEPTH:0] WC_MAX   = '1;
    localparam logic [3:0]     REL_INIT = 4'(RELEASE_CYCLES);

    state_t          state_q, state_d;
    logic [31:0]     wptr_q, wptr_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [DEPTH:0]  wc_q, wc_d;
    logic            err_q, err_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     din_q, din_d;
    logic            run_q, run_d;
    logic            core_reset_q, core_reset_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;

    logic            cmd_fire;
    logic            in_range;

    assign cmd_fire = cmd_valid_i & ready_q;
    assign in_range = ({1'b0, wptr_q} >= {1'b0, START_ADDR}) && ({1'b0, wptr_q} < END_ADDR);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            wptr_q       <= START_ADDR;
            cnt_q        <= '0;
            wc_q         <= '0;
            err_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            run_q        <= 1'b0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            cnt_q        <= cnt_d;
            wc_q         <= wc_d;
            err_q        <= err_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            run_q        <= run_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        cnt_d        = cnt_q;
        wc_d         = wc_q;
        err_d        = err_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        din_d        = din_q;
        run_d        = 1'b0;
        core_reset_d = core_reset_q;
        busy_d       = busy_q;

        case (state_q)
            S_IDLE, S_LOAD: begin
                if (cmd_fire) begin
                    case (cmd_op_i)
                        OP_SET_ADDR: begin
                            wptr_d  = cmd_data_i & ~32'd3;
                            state_d = S_LOAD;
                        end
                        OP_WRITE: begin
                            state_d = S_LOAD;
                            wptr_d  = wptr_q + 32'd4;
                            if (in_range) begin
                                we_d   = 1'b1;
                                addr_d = wptr_q;
                                din_d  = cmd_data_i;
                                if (wc_q != WC_MAX) begin
                                    wc_d = wc_q + 1'b1;
                                end
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_START: begin
                            state_d      = S_RELEASE;
                            core_reset_d = 1'b0;
                            busy_d       = 1'b1;
                            cnt_d        = REL_INIT;
                        end
                        default: begin
                            // HALT while loading leaves everything as it is.
                        end
                    endcase
                end
            end
            S_RELEASE: begin
                if (cnt_q <= 4'd1) begin
                    state_d = S_RUN;
                    run_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RUN: begin
                if (cmd_fire) begin
                    if (cmd_op_i == OP_HALT) begin
                        state_d      = S_IDLE;
                        core_reset_d = 1'b1;
                        busy_d       = 1'b0;
                        wc_d         = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Ready is registered, so it is derived from the state being entered.
    assign ready_d = (state_d != S_RELEASE);

    assign cmd_ready_o  = ready_q;
    assign core_reset_o = core_reset_q;
    assign run_o        = run_q;
    assign insn_addr_o  = addr_q;
    assign insn_din_o   = din_q;
    assign insn_we_o    = we_q;
    assign word_count_o = wc_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_imem_boot_controller.sv
// Directed bench for imem_boot_controller with default parameters (DEPTH=12, RELEASE_CYCLES=2).
module tb_imem_boot_controller;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [1:0]  cmd_op_i;
    logic [31:0] cmd_data_i;
    logic        core_reset_o;
    logic        run_o;
    logic [31:0] insn_addr_o;
    logic [31:0] insn_din_o;
    logic        insn_we_o;
    logic [12:0] word_count_o;
    logic        err_o;
    logic        busy_o;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [1:0] SET = 2'd0, WR = 2'd1, GO = 2'd2, HLT = 2'd3;

    imem_boot_controller dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_op_i     (cmd_op_i),
        .cmd_data_i   (cmd_data_i),
        .core_reset_o (core_reset_o),
        .run_o        (run_o),
        .insn_addr_o  (insn_addr_o),
        .insn_din_o   (insn_din_o),
        .insn_we_o    (insn_we_o),
        .word_count_o (word_count_o),
        .err_o        (err_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Presents one command for exactly one clock; returns just after the accepting edge.
    task automatic cmd(input logic [1:0] op, input logic [31:0] data);
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_data_i  = data;
        tick();
        cmd_valid_i = 1'b0;
    endtask

    // The write port must stay quiet whenever the core is out of reset.
    always @(negedge clk_i) begin
        if (reset_i === 1'b0 && core_reset_o === 1'b0)
            chk("we_while_running", {63'd0, insn_we_o}, 64'd0);
    end

    initial begin
        reset_i     = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 2'd0;
        cmd_data_i  = 32'd0;
        repeat (3) tick();
        reset_i = 1'b0;

        chk("rst_core_reset", {63'd0, core_reset_o}, 64'd1);
        chk("rst_run",        {63'd0, run_o},        64'd0);
        chk("rst_we",         {63'd0, insn_we_o},    64'd0);
        chk("rst_addr",       {32'd0, insn_addr_o},  64'd0);
        chk("rst_din",        {32'd0, insn_din_o},   64'd0);
        chk("rst_wc",         {51'd0, word_count_o}, 64'd0);
        chk("rst_err",        {63'd0, err_o},        64'd0);
        chk("rst_busy",       {63'd0, busy_o},       64'd0);
        chk("rst_ready",      {63'd0, cmd_ready_o},  64'd1);

        // Load two words back-to-back.
        cmd(SET, 32'h8000_0010);
        chk("set_no_we", {63'd0, insn_we_o}, 64'd0);
        cmd(WR, 32'hDEAD_BEEF);
        chk("w1_we",   {63'd0, insn_we_o},    64'd1);
        chk("w1_addr", {32'd0, insn_addr_o},  64'h8000_0010);
        chk("w1_din",  {32'd0, insn_din_o},   64'hDEAD_BEEF);
        chk("w1_wc",   {51'd0, word_count_o}, 64'd1);
        cmd(WR, 32'h0000_0013);
        chk("w2_we",   {63'd0, insn_we_o},    64'd1);
        chk("w2_addr", {32'd0, insn_addr_o},  64'h8000_0014);
        chk("w2_din",  {32'd0, insn_din_o},   64'h0000_0013);
        chk("w2_wc",   {51'd0, word_count_o}, 64'd2);
        chk("w2_err",  {63'd0, err_o},        64'd0);
        tick();
        chk("w_idle_we", {63'd0, insn_we_o}, 64'd0);

        cmd(HLT, 32'd0);
        chk("halt_load_core_reset", {63'd0, core_reset_o}, 64'd1);
        chk("halt_load_wc",         {51'd0, word_count_o}, 64'd2);

        // START: RELEASE for two cycles, then run pulse.
        cmd(GO, 32'd0);
        chk("s1_core_reset", {63'd0, core_reset_o}, 64'd0);
        chk("s1_busy",       {63'd0, busy_o},       64'd1);
        chk("s1_ready",      {63'd0, cmd_ready_o},  64'd0);
        chk("s1_run",        {63'd0, run_o},        64'd0);
        tick();
        chk("s2_ready",      {63'd0, cmd_ready_o},  64'd0);
        chk("s2_run",        {63'd0, run_o},        64'd0);
        chk("s2_busy",       {63'd0, busy_o},       64'd1);
        tick();
        chk("s3_run",        {63'd0, run_o},        64'd1);
        chk("s3_ready",      {63'd0, cmd_ready_o},  64'd1);
        tick();
        chk("s4_run",        {63'd0, run_o},        64'd0);
        chk("s4_busy",       {63'd0, busy_o},       64'd1);
        chk("s4_core_reset", {63'd0, core_reset_o}, 64'd0);

        // Commands other than HALT in RUN only flag an error.
        cmd(WR, 32'h0000_0001);
        chk("run_wr_we",  {63'd0, insn_we_o}, 64'd0);
        chk("run_wr_err", {63'd0, err_o},     64'd1);
        cmd(HLT, 32'd0);
        chk("halt_core_reset", {63'd0, core_reset_o}, 64'd1);
        chk("halt_busy",       {63'd0, busy_o},       64'd0);
        chk("halt_wc",         {51'd0, word_count_o}, 64'd0);
        chk("halt_err",        {63'd0, err_o},        64'd1);

        // Reload continues from the retained write pointer.
        cmd(WR, 32'h0000_00AA);
        chk("rl_we",   {63'd0, insn_we_o},    64'd1);
        chk("rl_addr", {32'd0, insn_addr_o},  64'h8000_0018);
        chk("rl_wc",   {51'd0, word_count_o}, 64'd1);
        cmd(GO, 32'd0);
        tick();
        tick();
        chk("rl_run", {63'd0, run_o}, 64'd1);
        cmd(HLT, 32'd0);

        // Reset in the middle of RELEASE.
        cmd(GO, 32'd0);
        chk("r5_core_reset_pre", {63'd0, core_reset_o}, 64'd0);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("r5_core_reset", {63'd0, core_reset_o}, 64'd1);
        chk("r5_busy",       {63'd0, busy_o},       64'd0);
        chk("r5_err",        {63'd0, err_o},        64'd0);
        chk("r5_wc",         {51'd0, word_count_o}, 64'd0);
        chk("r5_addr",       {32'd0, insn_addr_o},  64'd0);
        chk("r5_ready",      {63'd0, cmd_ready_o},  64'd1);
        for (int i = 0; i < 4; i++) begin
            chk("r5_no_run", {63'd0, run_o}, 64'd0);
            tick();
        end

        // One past the end of imem.
        cmd(SET, 32'h8000_4000);
        cmd(WR, 32'h0000_0055);
        chk("oor_we",  {63'd0, insn_we_o},    64'd0);
        chk("oor_err", {63'd0, err_o},        64'd1);
        chk("oor_wc",  {51'd0, word_count_o}, 64'd0);

        // Last valid word, then the pointer steps out of range.
        cmd(SET, 32'h8000_3FFC);
        cmd(WR, 32'h1234_5678);
        chk("last_we",   {63'd0, insn_we_o},   64'd1);
        chk("last_addr", {32'd0, insn_addr_o}, 64'h8000_3FFC);
        cmd(WR, 32'h1111_1111);
        chk("past_we",   {63'd0, insn_we_o},   64'd0);

        // Below the window and 32-bit wrap are both out of range.
        cmd(SET, 32'h7FFF_FFFC);
        cmd(WR, 32'h2222_2222);
        chk("below_we", {63'd0, insn_we_o}, 64'd0);
        cmd(SET, 32'hFFFF_FFFC);
        cmd(WR, 32'h3333_3333);
        chk("top_we",  {63'd0, insn_we_o}, 64'd0);
        cmd(WR, 32'h4444_4444);
        chk("wrap_we", {63'd0, insn_we_o}, 64'd0);

        // Unaligned SET_ADDR has its low two bits dropped.
        cmd(SET, 32'h8000_0003);
        cmd(WR, 32'h0000_0077);
        chk("align_we",   {63'd0, insn_we_o},    64'd1);
        chk("align_addr", {32'd0, insn_addr_o},  64'h8000_0000);
        chk("align_din",  {32'd0, insn_din_o},   64'h0000_0077);
        chk("align_wc",   {51'd0, word_count_o}, 64'd2);

        // Ungated valid is ignored while cmd_ready is low.
        cmd(GO, 32'd0);
        cmd(WR, 32'h5555_5555);
        chk("rel_ignored_err", {63'd0, err_o}, 64'd1);
        chk("rel_ignored_we",  {63'd0, insn_we_o}, 64'd0);
        tick();
        chk("rel_run", {63'd0, run_o}, 64'd1);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
